// File: rtl/mbyte_addsub_seq_if.sv
// Operation and adder-facing bus for the multi-byte add/subtract sequencer.
// The slave modport is the sequencer; master is the controller plus the adder.
interface mbyte_addsub_seq_if #(
    parameter int BYTES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*BYTES-1:0]   in_a;
    logic [8*BYTES-1:0]   in_b;
    logic                 in_sub;
    logic                 in_cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*BYTES-1:0]   out_result;
    logic                 out_cout;
    logic                 out_ovf;
    logic                 out_zero;
    logic [7:0]           cla_x;
    logic [7:0]           cla_y;
    logic                 cla_mode;
    logic                 cla_cin;
    logic [7:0]           cla_sum;
    logic                 cla_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready, cla_sum, cla_cout,
        output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero,
        output cla_x, cla_y, cla_mode, cla_cin
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready, cla_sum, cla_cout,
        input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero,
        input  cla_x, cla_y, cla_mode, cla_cin
    );
endinterface

// File: rtl/mbyte_addsub_seq.sv
// BYTES x 8-bit add/subtract, streamed LSB-first through an external 8-bit adder.
// Optional MBADD_BACKTOBACK_EN: retire a result and accept the next op on one edge.
module mbyte_addsub_seq #(
    parameter int BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mbyte_addsub_seq_if.slave bus
);
    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, result_q;
    logic            sub_q, carry_q, ovf_q, zero_q;
    logic [IW-1:0]   idx_q;
    logic            accept;
    logic            last_byte;
    logic [W-1:0]    a_shift, b_shift;

    assign last_byte = (idx_q == IW'(BYTES - 1));
    assign a_shift   = a_q >> {idx_q, 3'b000};
    assign b_shift   = b_q >> {idx_q, 3'b000};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.cla_x     = 8'h00;
        bus.cla_y     = 8'h00;
        bus.cla_mode  = 1'b0;
        bus.cla_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.cla_x    = a_shift[7:0];
                bus.cla_y    = b_shift[7:0];
                bus.cla_mode = sub_q;
                bus.cla_cin  = carry_q;
                if (last_byte) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
`ifdef MBADD_BACKTOBACK_EN
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (bus.out_ready) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.in_a;
                b_q     <= bus.in_b;
                sub_q   <= bus.in_sub;
                carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
                idx_q   <= '0;
            end else if (state_q == BUSY) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (idx_q == IW'(i)) result_q[8*i +: 8] <= bus.cla_sum;
                end
                carry_q <= bus.cla_cout;
                idx_q   <= idx_q + IW'(1);
                // Flags are captured alongside the top byte so they never glitch in DONE.
                if (last_byte) begin
                    ovf_q  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (bus.cla_sum[7] != a_q[W-1]);
                    zero_q <= ~|bus.cla_sum && ~|result_q[W-9:0];
                end
            end
        end
    end

    assign bus.out_result = result_q;
    assign bus.out_cout   = carry_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_zero   = zero_q;
endmodule
